condicionador_entrada: RTL and testbench
========================================

Name: condicionador_entrada

Overview:
- Front-end input conditioner for the 4-bit calculator. It sits directly upstream of the calculator top level and drives that level's Dados and Instrucao inputs.
- It synchronises the raw board switches and the instruction push-button, then debounces the button.
- For each clean press it emits exactly one single-cycle instruction pulse. In the same clock edge it latches a switch value that stays stable until the next press.
- This gives the calculator's Mealy controller one clean step per physical press. The operand seen by registers A and B never changes mid-operation.

Parameters:
- DEB_CYCLES, 250000: consecutive stable synchronised cycles required to accept a press or a release. Minimum legal value is 2.
- CNT_W, 18: width of the debounce counter. Must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset. 0 = reset asserted.
- btn_raw  in  1  raw instruction button. Active-high, asynchronous, bouncy.
- sw_raw  in  4  raw data switches. Asynchronous.
- dados  out  4  switch value latched at the last accepted press. Feeds Dados.
- instrucao  out  1  one-cycle pulse per accepted press. Feeds Instrucao.
- btn_nivel  out  1  debounced button level. 1 in HELD and DB_RELEASE.
- n_press  out  8  count of accepted presses, for debug.

Behaviour:
- Reset (rst=0, asynchronous):
  - All synchroniser flops, counter, state, dados, instrucao and n_press go to 0.
  - State goes to IDLE.
  - Takes effect immediately, with no clock edge needed.
- Synchroniser:
  - Two flops per bit on btn_raw and on sw_raw[3:0], giving btn_s and sw_s.
  - No logic between the two flops.
- FSM states: IDLE, DB_PRESS, HELD, DB_RELEASE. Counter cnt is CNT_W bits.
- IDLE:
  - btn_s=1 -> DB_PRESS with cnt<=0.
  - Otherwise stay in IDLE.
- DB_PRESS:
  - btn_s=0 -> IDLE with cnt<=0. This is a bounce rejection: no pulse, no latch.
  - btn_s=1 and cnt<DEB_CYCLES-1 -> cnt<=cnt+1.
  - btn_s=1 and cnt==DEB_CYCLES-1 -> HELD (commit edge). At the commit edge:
    - instrucao<=1
    - dados<=sw_s
    - n_press<=n_press+1, wrapping 255->0.
- HELD:
  - btn_s=0 -> DB_RELEASE with cnt<=0.
  - Otherwise stay in HELD.
- DB_RELEASE:
  - btn_s=1 -> HELD with cnt<=0. No new pulse.
  - btn_s=0 and cnt==DEB_CYCLES-1 -> IDLE.
  - Otherwise cnt<=cnt+1.
- instrucao:
  - Registered output, high for exactly one cycle after each commit edge, otherwise 0.
  - A continuously held button never re-pulses; no auto-repeat.
- Latency:
  - Let edge 0 be the first rising edge that samples btn_raw=1, with btn_raw held high from then on.
  - instrucao is 1 during the cycle following edge DEB_CYCLES+2.
  - dados updates at the same edge.
- dados:
  - Changes only at commit edges.
  - Switch movement between presses is invisible on dados.
- Switch changes during debounce:
  - Whatever sw_s holds at the commit edge is latched.
  - No debounce is applied to the switches; the operator sets switches before pressing.
- Reset mid-operation:
  - Any state is abandoned and no pulse is emitted.
  - If the button is still held when rst releases, it is treated as a fresh press from IDLE. It needs a full DEB_CYCLES of stability and then yields one pulse.
- Glitch shorter than DEB_CYCLES in HELD: absorbed, no pulse.
- Minimum press-to-press spacing for two pulses: 2*DEB_CYCLES+O(3) cycles.

Decomposition:
- Shared package (condicionador_pkg):
  - State encoding localparams: ST_IDLE=2'd0, ST_DB_PRESS=2'd1, ST_HELD=2'd2, ST_DB_RELEASE=2'd3.
  - Default DEB_CYCLES constant.
- One sub-module: sincronizador, a parameterised-width two-flop synchroniser with async active-low clear.
  - One instance of width 5 carries {btn_raw, sw_raw}.
- FSM, counter and output registers live in condicionador_entrada.

Test Plan:
All scenarios use DEB_CYCLES=4, CNT_W=3.
- Clean press:
  - Stimulus: rst low 3 cycles, then high; sw_raw=4'hA; btn_raw=1 from edge 0 and held.
  - Response: instrucao=1 only during the cycle after edge 6; dados=4'hA from edge 6; n_press=1; btn_nivel=1.
- Bounce rejection:
  - Stimulus: btn_raw pattern 1,1,0,1,0,1,1,0 per cycle, then 0 for 20 cycles.
  - Response: instrucao stays 0; dados stays 0; n_press=0; state returns to IDLE.
- Hold and release glitch:
  - Stimulus: after a commit with button held for 50 cycles, drop btn_raw for 2 cycles, raise it for 10 cycles, then release for good.
  - Response: exactly one pulse in total; n_press=1; btn_nivel falls 6 cycles after the final release edge.
- Data isolation:
  - Stimulus: press with sw_raw=4'h3; after release change sw to 4'hF; press again.
  - Response: dados=4'h3 until the second commit edge, then 4'hF; two pulses; n_press=2.
- Reset mid-debounce:
  - Stimulus: assert rst=0 asynchronously at cnt=2 in DB_PRESS, mid-cycle, with button still held; release rst.
  - Response: all outputs 0 immediately with no clock edge; one pulse 7 edges after rst release; dados equals the current sw_raw.
- Counter wrap:
  - Stimulus: 256 clean presses with sw_raw=4'h5.
  - Response: n_press reads 255 after 255 presses and 0 after the 256th; 256 pulses counted.

Source files
------------

// File: rtl/condicionador_pkg.sv
// condicionador_pkg: shared types and constants for the calculator
// input conditioner (state encoding and default debounce sizing).
package condicionador_pkg;

   localparam int DEB_CYCLES_DEF = 250000;
   localparam int CNT_W_DEF      = 18;
   localparam int SW_W           = 4;
   localparam int NP_W           = 8;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_DB_PRESS   = 2'd1,
      ST_HELD       = 2'd2,
      ST_DB_RELEASE = 2'd3
   } estado_t;

   // The button counts as down while held or while a release is pending.
   function automatic logic nivel_alto(input estado_t st);
      return (st == ST_HELD) || (st == ST_DB_RELEASE);
   endfunction

endpackage

// File: rtl/sincronizador.sv
// sincronizador: two-flop synchroniser with asynchronous active-low clear.
// Bits are synchronised independently; no logic between the two stages.
module sincronizador #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/condicionador_entrada.sv
// condicionador_entrada: synchronises switches and button, debounces the
// button and emits one instruction pulse plus a latched operand per press.
module condicionador_entrada
   import condicionador_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            btn_raw,
   input  logic [SW_W-1:0] sw_raw,
   output logic [SW_W-1:0] dados,
   output logic            instrucao,
   output logic            btn_nivel,
   output logic [NP_W-1:0] n_press
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic            btn_s;
   logic [SW_W-1:0] sw_s;
   estado_t         state;
   logic [CNT_W-1:0] cnt;

   sincronizador #(
      .W (SW_W + 1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   ({btn_raw, sw_raw}),
      .q   ({btn_s, sw_s})
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         dados     <= '0;
         instrucao <= 1'b0;
         n_press   <= '0;
      end else begin
         instrucao <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (btn_s) begin
                  state <= ST_DB_PRESS;
                  cnt   <= '0;
               end
            end
            ST_DB_PRESS: begin
               if (!btn_s) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  // Commit: pulse and operand capture share this edge.
                  state     <= ST_HELD;
                  instrucao <= 1'b1;
                  dados     <= sw_s;
                  n_press   <= n_press + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_HELD: begin
               if (!btn_s) begin
                  state <= ST_DB_RELEASE;
                  cnt   <= '0;
               end
            end
            ST_DB_RELEASE: begin
               if (btn_s) begin
                  state <= ST_HELD;
                  cnt   <= '0;
               end else if (cnt == CNT_MAX) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign btn_nivel = nivel_alto(state);

endmodule

// File: tb/tb_condicionador_entrada.sv
// tb_condicionador_entrada: directed checks of the input conditioner
// with DEB_CYCLES=4, CNT_W=3.
module tb_condicionador_entrada;
   import condicionador_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_raw = 1'b0;
   logic [3:0] sw_raw = 4'h0;
   logic [3:0] dados;
   logic       instrucao;
   logic       btn_nivel;
   logic [7:0] n_press;

   int n_assert = 0;
   int n_fail   = 0;
   int pulses   = 0;
   int p0       = 0;

   condicionador_entrada #(
      .DEB_CYCLES (4),
      .CNT_W      (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .sw_raw    (sw_raw),
      .dados     (dados),
      .instrucao (instrucao),
      .btn_nivel (btn_nivel),
      .n_press   (n_press)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (instrucao === 1'b1) pulses++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic do_press(input logic [3:0] sw);
      sw_raw  = sw;
      btn_raw = 1'b1;
      tick(8);
      btn_raw = 1'b0;
      tick(8);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(1);
   endtask

   initial begin
      // Reset state
      sw_raw = 4'hA;
      tick(3);
      chk("rst_dados", 32'(dados), 32'h0);
      chk("rst_instr", 32'(instrucao), 32'h0);
      chk("rst_npress", 32'(n_press), 32'h0);
      chk("rst_nivel", 32'(btn_nivel), 32'h0);
      rst = 1'b1;
      tick(1);

      // Bounce rejection
      p0 = pulses;
      btn_raw = 1'b1; tick(1);
      btn_raw = 1'b1; tick(1);
      btn_raw = 1'b0; tick(1);
      btn_raw = 1'b1; tick(1);
      btn_raw = 1'b0; tick(1);
      btn_raw = 1'b1; tick(1);
      btn_raw = 1'b1; tick(1);
      btn_raw = 1'b0; tick(1);
      tick(20);
      chk("bnc_pulses", 32'(pulses - p0), 32'd0);
      chk("bnc_dados", 32'(dados), 32'h0);
      chk("bnc_npress", 32'(n_press), 32'h0);
      chk("bnc_state", 32'(dut.state), 32'(ST_IDLE));

      // Clean press: commit at edge 6
      p0 = pulses;
      sw_raw  = 4'hA;
      btn_raw = 1'b1;
      tick(6);
      chk("cp_instr_e5", 32'(instrucao), 32'h0);
      chk("cp_dados_e5", 32'(dados), 32'h0);
      tick(1);
      chk("cp_instr_e6", 32'(instrucao), 32'h1);
      chk("cp_dados_e6", 32'(dados), 32'hA);
      chk("cp_npress", 32'(n_press), 32'h1);
      chk("cp_nivel", 32'(btn_nivel), 32'h1);
      tick(1);
      chk("cp_instr_e7", 32'(instrucao), 32'h0);

      // Hold, short glitch, final release
      tick(50);
      btn_raw = 1'b0;
      tick(2);
      btn_raw = 1'b1;
      tick(10);
      chk("gl_nivel", 32'(btn_nivel), 32'h1);
      btn_raw = 1'b0;
      tick(6);
      chk("gl_nivel_e5", 32'(btn_nivel), 32'h1);
      tick(1);
      chk("gl_nivel_e6", 32'(btn_nivel), 32'h0);
      chk("gl_pulses", 32'(pulses - p0), 32'd1);
      chk("gl_npress", 32'(n_press), 32'h1);
      tick(4);

      // Data isolation
      do_reset();
      p0 = pulses;
      sw_raw  = 4'h3;
      btn_raw = 1'b1;
      tick(10);
      chk("di_dados1", 32'(dados), 32'h3);
      btn_raw = 1'b0;
      tick(3);
      sw_raw = 4'hF;
      tick(10);
      chk("di_dados_idle", 32'(dados), 32'h3);
      btn_raw = 1'b1;
      tick(6);
      chk("di_dados_e5", 32'(dados), 32'h3);
      tick(1);
      chk("di_dados_e6", 32'(dados), 32'hF);
      chk("di_instr_e6", 32'(instrucao), 32'h1);
      btn_raw = 1'b0;
      tick(10);
      chk("di_pulses", 32'(pulses - p0), 32'd2);
      chk("di_npress", 32'(n_press), 32'h2);

      // Reset mid-debounce at cnt=2
      sw_raw  = 4'h7;
      btn_raw = 1'b1;
      tick(5);
      chk("rm_state", 32'(dut.state), 32'(ST_DB_PRESS));
      chk("rm_cnt", 32'(dut.cnt), 32'd2);
      #2;
      rst = 1'b0;
      #1;
      chk("rm_dados", 32'(dados), 32'h0);
      chk("rm_npress", 32'(n_press), 32'h0);
      chk("rm_instr", 32'(instrucao), 32'h0);
      chk("rm_st_idle", 32'(dut.state), 32'(ST_IDLE));
      sw_raw = 4'h9;
      tick(2);
      p0 = pulses;
      rst = 1'b1;
      tick(6);
      chk("rm_instr_e5", 32'(instrucao), 32'h0);
      tick(1);
      chk("rm_instr_e6", 32'(instrucao), 32'h1);
      chk("rm_dados_e6", 32'(dados), 32'h9);
      chk("rm_npress_e6", 32'(n_press), 32'h1);
      btn_raw = 1'b0;
      tick(10);
      chk("rm_pulses", 32'(pulses - p0), 32'd1);

      // Counter wrap
      do_reset();
      p0 = pulses;
      for (int i = 0; i < 255; i++) do_press(4'h5);
      chk("wr_255", 32'(n_press), 32'hFF);
      do_press(4'h5);
      chk("wr_0", 32'(n_press), 32'h0);
      chk("wr_pulses", 32'(pulses - p0), 32'd256);
      chk("wr_dados", 32'(dados), 32'h5);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
